multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller with a memory req/ready handshake and sticky FAULT.
// Define CTRL_PERF_CNT_EN to build the saturating retired/stall counters; otherwise both count ports read 0.
module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 5,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                fault_clr,
  output logic                reg_write,
  output logic                branch,
  output logic                ALU_src,
  output logic                load,
  output logic                immediate_signal,
  output logic                mem_write,
  output logic                jump,
  output logic                PC_enable,
  output logic                IR_enable,
  output logic                mem_enable,
  output logic                reg_enable,
  output logic                mem_req,
  output logic                instr_done,
  output logic                fault,
  output logic [2:0]          state_out,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_ITYPE, C_BRANCH, C_JUMP, C_LOAD, C_STORE, C_ILLEGAL
  } class_e;

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  function automatic class_e classify(input logic [OPCODE_W-1:0] op);
    class_e c;
    if (op[OPCODE_W-1])                                c = C_ITYPE;
    else if (op < OPCODE_W'(7))                        c = C_RTYPE;
    else if (op == OPCODE_W'(7) || op == OPCODE_W'(8)) c = C_BRANCH;
    else if (op == OPCODE_W'(9))                       c = C_LOAD;
    else if (op == OPCODE_W'(10))                      c = C_STORE;
    else if (op == OPCODE_W'(11))                      c = C_JUMP;
    else                                               c = C_ILLEGAL;
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  class_e              cls_live, cls_lat;
  logic                waiting, timeout_hit;

  logic reg_write_c, branch_c, alu_src_c, load_c, imm_c, mem_write_c, jump_c;
  logic pc_en_c, ir_en_c, mem_en_c, reg_en_c, mem_req_c, done_c, fault_c;

  assign cls_live = classify(opcode);
  assign cls_lat  = classify(opc_q);

  always_comb begin
    state_d     = state_q;
    reg_write_c = 1'b0;
    branch_c    = 1'b0;
    alu_src_c   = 1'b0;
    load_c      = 1'b0;
    imm_c       = 1'b0;
    mem_write_c = 1'b0;
    jump_c      = 1'b0;
    pc_en_c     = 1'b0;
    ir_en_c     = 1'b0;
    mem_en_c    = 1'b0;
    reg_en_c    = 1'b0;
    mem_req_c   = 1'b0;
    done_c      = 1'b0;
    fault_c     = 1'b0;
    waiting     = (state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready;
    // mem_ready in the final allowed cycle still advances normally
    timeout_hit = (TIMEOUT > 0) && waiting && (wait_q == WAIT_LAST);

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        mem_en_c  = 1'b1;
        if (mem_ready) begin
          ir_en_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        reg_en_c = 1'b1;
        state_d  = (cls_live == C_ILLEGAL) ? S_FAULT : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (cls_lat)
          C_RTYPE: begin
            alu_src_c = 1'b1;
            state_d   = S_WRITEBACK;
          end
          C_ITYPE: begin
            imm_c   = 1'b1;
            state_d = S_WRITEBACK;
          end
          C_BRANCH: begin
            alu_src_c = 1'b1;
            branch_c  = 1'b1;
            pc_en_c   = 1'b1;
            done_c    = 1'b1;
            state_d   = S_FETCH;
          end
          C_JUMP: begin
            jump_c  = 1'b1;
            pc_en_c = 1'b1;
            done_c  = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: begin
            alu_src_c = 1'b1;
            state_d   = S_MEMORY;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        mem_req_c = 1'b1;
        mem_en_c  = 1'b1;
        if (cls_lat == C_LOAD) begin
          load_c = 1'b1;
          imm_c  = 1'b1;
        end else begin
          mem_write_c = 1'b1;
        end
        if (mem_ready) begin
          if (cls_lat == C_LOAD) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_en_c = 1'b1;
            done_c  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        reg_en_c    = 1'b1;
        reg_write_c = 1'b1;
        pc_en_c     = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_FAULT: begin
        fault_c = 1'b1;
        if (fault_clr) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    wait_d = (waiting && state_d == state_q) ? wait_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) opc_q <= opcode;
    end
  end

  // Every output is forced low for as long as reset is held, including mem_req in FETCH.
  assign reg_write        = reg_write_c & ~reset;
  assign branch           = branch_c    & ~reset;
  assign ALU_src          = alu_src_c   & ~reset;
  assign load             = load_c      & ~reset;
  assign immediate_signal = imm_c       & ~reset;
  assign mem_write        = mem_write_c & ~reset;
  assign jump             = jump_c      & ~reset;
  assign PC_enable        = pc_en_c     & ~reset;
  assign IR_enable        = ir_en_c     & ~reset;
  assign mem_enable       = mem_en_c    & ~reset;
  assign reg_enable       = reg_en_c    & ~reset;
  assign mem_req          = mem_req_c   & ~reset;
  assign instr_done       = done_c      & ~reset;
  assign fault            = fault_c     & ~reset;
  assign state_out        = reset ? 3'd0 : state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (done_c && !(&retired_q)) retired_q <= retired_q + 1'b1;
      if (waiting && !(&stall_q))  stall_q   <= stall_q + 1'b1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (TIMEOUT=4): per-cycle state/control vectors against hand-computed tables.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  opcode = 5'd0;
  logic        mem_ready = 1'b1;
  logic        fault_clr = 1'b0;
  logic        reg_write, branch, ALU_src, load, immediate_signal, mem_write, jump;
  logic        PC_enable, IR_enable, mem_enable, reg_enable, mem_req, instr_done, fault;
  logic [2:0]  state_out;
  logic [15:0] retired_cnt, stall_cnt;
  logic [13:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OPCODE_W(5), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .fault_clr(fault_clr),
    .reg_write(reg_write), .branch(branch), .ALU_src(ALU_src), .load(load),
    .immediate_signal(immediate_signal), .mem_write(mem_write), .jump(jump),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .mem_enable(mem_enable),
    .reg_enable(reg_enable), .mem_req(mem_req), .instr_done(instr_done), .fault(fault),
    .state_out(state_out), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  assign ctl = {reg_write, branch, ALU_src, load, immediate_signal, mem_write, jump,
                PC_enable, IR_enable, mem_enable, reg_enable, mem_req, instr_done, fault};

  localparam logic [13:0] B_RW = 14'h2000, B_BR = 14'h1000, B_AS = 14'h0800, B_LD = 14'h0400;
  localparam logic [13:0] B_IM = 14'h0200, B_MW = 14'h0100, B_JP = 14'h0080, B_PE = 14'h0040;
  localparam logic [13:0] B_IE = 14'h0020, B_ME = 14'h0010, B_RE = 14'h0008, B_MQ = 14'h0004;
  localparam logic [13:0] B_ID = 14'h0002, B_FT = 14'h0001;

  localparam logic [13:0] E_FW   = B_MQ | B_ME;
  localparam logic [13:0] E_FR   = B_MQ | B_ME | B_IE;
  localparam logic [13:0] E_DEC  = B_RE;
  localparam logic [13:0] E_EXR  = B_AS;
  localparam logic [13:0] E_EXI  = B_IM;
  localparam logic [13:0] E_EXB  = B_AS | B_BR | B_PE | B_ID;
  localparam logic [13:0] E_EXJ  = B_JP | B_PE | B_ID;
  localparam logic [13:0] E_MLD  = B_MQ | B_ME | B_LD | B_IM;
  localparam logic [13:0] E_MST  = B_MQ | B_ME | B_MW;
  localparam logic [13:0] E_MSTR = B_MQ | B_ME | B_MW | B_PE | B_ID;
  localparam logic [13:0] E_WB   = B_RE | B_RW | B_PE | B_ID;
  localparam logic [13:0] E_FLT  = B_FT;

`ifdef CTRL_PERF_CNT_EN
  localparam logic [15:0] LOAD_RET = 16'd1, LOAD_STALL = 16'd3, BJ_RET = 16'd2;
`else
  localparam logic [15:0] LOAD_RET = 16'd0, LOAD_STALL = 16'd0, BJ_RET = 16'd0;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic        rdy;
    logic        clr;
    logic [2:0]  st;
    logic [13:0] ctl;
  } vec_t;

  task automatic drive(input logic [4:0] op, input logic rdy, input logic clr);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    fault_clr = clr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    fault_clr = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if ({state_out, ctl, retired_cnt, stall_cnt} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d ctl=%b ret=%0d stall=%0d, expected all zero",
               state_out, ctl, retired_cnt, stall_cnt);
    end
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({state_out, ctl} !== {3'd0, E_FW}) begin
      n_err++;
      $display("FAIL reset_release: state=%0d ctl=%b, expected state=0 ctl=%b", state_out, ctl, E_FW);
    end
  endtask

  task automatic test_add();
    vec_t tbl [4] = '{'{5'd0, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd0, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd0, 1'b1, 1'b0, 3'd2, E_EXR}, '{5'd0, 1'b1, 1'b0, 3'd4, E_WB}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL add[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_load_wait();
    vec_t tbl [8] = '{'{5'd9, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd9, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd9, 1'b1, 1'b0, 3'd2, E_EXR}, '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD},
                      '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD}, '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD},
                      '{5'd9, 1'b1, 1'b0, 3'd3, E_MLD}, '{5'd9, 1'b1, 1'b0, 3'd4, E_WB}};
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL load[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({retired_cnt, stall_cnt} !== {LOAD_RET, LOAD_STALL}) begin
      n_err++;
      $display("FAIL load_counters: ret=%0d stall=%0d, expected ret=%0d stall=%0d",
               retired_cnt, stall_cnt, LOAD_RET, LOAD_STALL);
    end
  endtask

  task automatic test_branch_jump();
    vec_t tbl [6] = '{'{5'd7, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd7, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd7, 1'b1, 1'b0, 3'd2, E_EXB}, '{5'd11, 1'b1, 1'b0, 3'd0, E_FR},
                      '{5'd11, 1'b1, 1'b0, 3'd1, E_DEC}, '{5'd11, 1'b1, 1'b0, 3'd2, E_EXJ}};
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL branch_jump[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({retired_cnt, stall_cnt} !== {BJ_RET, 16'd0}) begin
      n_err++;
      $display("FAIL branch_jump_counters: ret=%0d stall=%0d, expected ret=%0d stall=0",
               retired_cnt, stall_cnt, BJ_RET);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl [15] = '{'{5'd16, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd16, 1'b1, 1'b0, 3'd1, E_DEC},
                       '{5'd16, 1'b1, 1'b0, 3'd2, E_EXI}, '{5'd16, 1'b1, 1'b0, 3'd4, E_WB},
                       '{5'd10, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd10, 1'b1, 1'b0, 3'd1, E_DEC},
                       '{5'd10, 1'b1, 1'b0, 3'd2, E_EXR}, '{5'd10, 1'b1, 1'b0, 3'd3, E_MSTR},
                       '{5'd8, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd8, 1'b1, 1'b0, 3'd1, E_DEC},
                       '{5'd8, 1'b1, 1'b0, 3'd2, E_EXB}, '{5'd6, 1'b1, 1'b0, 3'd0, E_FR},
                       '{5'd6, 1'b1, 1'b0, 3'd1, E_DEC}, '{5'd6, 1'b1, 1'b0, 3'd2, E_EXR},
                       '{5'd6, 1'b1, 1'b0, 3'd4, E_WB}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_ready_wins();
    vec_t tbl [6] = '{'{5'd7, 1'b0, 1'b0, 3'd0, E_FW}, '{5'd7, 1'b0, 1'b0, 3'd0, E_FW},
                      '{5'd7, 1'b0, 1'b0, 3'd0, E_FW}, '{5'd7, 1'b1, 1'b0, 3'd0, E_FR},
                      '{5'd7, 1'b1, 1'b0, 3'd1, E_DEC}, '{5'd7, 1'b1, 1'b0, 3'd2, E_EXB}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL ready_wins[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t tbl [4] = '{'{5'd13, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd13, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd13, 1'b1, 1'b0, 3'd5, E_FLT}, '{5'd13, 1'b1, 1'b1, 3'd5, E_FLT}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL illegal[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_timeout_fetch();
    vec_t tbl [7] = '{'{5'd0, 1'b0, 1'b0, 3'd0, E_FW}, '{5'd0, 1'b0, 1'b0, 3'd0, E_FW},
                      '{5'd0, 1'b0, 1'b0, 3'd0, E_FW}, '{5'd0, 1'b0, 1'b0, 3'd0, E_FW},
                      '{5'd0, 1'b1, 1'b0, 3'd5, E_FLT}, '{5'd0, 1'b0, 1'b1, 3'd5, E_FLT},
                      '{5'd0, 1'b0, 1'b0, 3'd0, E_FW}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL timeout_fetch[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_timeout_mem();
    vec_t tbl [8] = '{'{5'd9, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd9, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd9, 1'b1, 1'b0, 3'd2, E_EXR}, '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD},
                      '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD}, '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD},
                      '{5'd9, 1'b0, 1'b0, 3'd3, E_MLD}, '{5'd9, 1'b0, 1'b1, 3'd5, E_FLT}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL timeout_mem[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    vec_t tbl [4] = '{'{5'd10, 1'b1, 1'b0, 3'd0, E_FR}, '{5'd10, 1'b1, 1'b0, 3'd1, E_DEC},
                      '{5'd10, 1'b1, 1'b0, 3'd2, E_EXR}, '{5'd10, 1'b0, 1'b0, 3'd3, E_MST}};
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].clr);
      n_cmp++;
      if ({state_out, ctl} !== {tbl[i].st, tbl[i].ctl}) begin
        n_err++;
        $display("FAIL reset_store[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_out, ctl, tbl[i].st, tbl[i].ctl);
      end
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({state_out, ctl, retired_cnt, stall_cnt} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_store_abort: state=%0d ctl=%b ret=%0d stall=%0d, expected all zero",
               state_out, ctl, retired_cnt, stall_cnt);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({state_out, ctl, retired_cnt, stall_cnt} !== {3'd0, E_FW, 32'd0}) begin
      n_err++;
      $display("FAIL reset_store_release: state=%0d ctl=%b ret=%0d stall=%0d, expected state=0 ctl=%b counts 0",
               state_out, ctl, retired_cnt, stall_cnt, E_FW);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch_jump();
    test_back_to_back();
    test_ready_wins();
    test_illegal();
    test_timeout_fetch();
    test_timeout_mem();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
